// File: rtl/iob_cpu_bus_split_pkg.sv
// Shared definitions for the CPU bus splitter.
//   - bus_state_e : transaction FSM encoding (idle, issue, response)
//   - RemapBitFromMsb / remap_bit() : location of the fetch remap bit that is
//     replaced by ~boot on the instruction bus
// No ports; imported by iob_cpu_bus_split and iob_bus_timeout.
package iob_cpu_bus_split_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StResp  = 2'd2
  } bus_state_e;

  // Fetch remap bit, counted down from the address MSB.
  localparam int unsigned RemapBitFromMsb = 0;

  function automatic int unsigned remap_bit(input int unsigned addr_w);
    return addr_w - 1 - RemapBitFromMsb;
  endfunction

endpackage

// File: rtl/iob_bus_timeout.sv
// Bus access watchdog with sticky error capture.
//   clk_i      : clock (rising edge)
//   rst_ni     : synchronous active-low reset
//   issue_i    : FSM is in the issue state (a bus valid is asserted)
//   ready_i    : ready of the currently selected bus
//   addr_i     : address presented on the selected bus
//   timeout_o  : access gives up this cycle (never together with ready_i)
//   bus_err_o  : sticky error flag, cleared only by reset
//   err_addr_o : address of the first access that timed out
module iob_bus_timeout
  import iob_cpu_bus_split_pkg::*;
#(
  parameter int unsigned TIMEOUT_W = 8,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              issue_i,
  input  logic              ready_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              timeout_o,
  output logic              bus_err_o,
  output logic [ADDR_W-1:0] err_addr_o
);

  // The counter reaches all-ones on the edge that ends the access.
  localparam logic [TIMEOUT_W-1:0] CntLast = {TIMEOUT_W{1'b1}} - TIMEOUT_W'(1);

  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 bus_err_q, bus_err_d;
  logic [ADDR_W-1:0]    err_addr_q, err_addr_d;

  always_comb begin
    // Counter rests at zero outside the issue state, so it is clear on entry.
    cnt_d      = '0;
    timeout_o  = 1'b0;
    bus_err_d  = bus_err_q;
    err_addr_d = err_addr_q;
    if (issue_i && !ready_i) begin
      cnt_d     = cnt_q + TIMEOUT_W'(1);
      timeout_o = (cnt_q == CntLast);
    end
    if (timeout_o) begin
      bus_err_d = 1'b1;
      if (!bus_err_q) err_addr_d = addr_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q      <= '0;
      bus_err_q  <= 1'b0;
      err_addr_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      bus_err_q  <= bus_err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign bus_err_o  = bus_err_q;
  assign err_addr_o = err_addr_q;

endmodule

// File: rtl/iob_cpu_bus_split.sv
// Splits a native CPU request into an instruction bus and N_DBUS data buses.
// One transaction is outstanding at a time: IDLE -> ISSUE -> RESP -> IDLE.
// Ports:
//   clk, resetn (synchronous, active-low), boot (1 = boot ROM phase)
//   cpu_valid/cpu_instr/cpu_addr/cpu_wdata/cpu_wstrb -> request
//   cpu_rdata/cpu_ready                               <- one-cycle response
//   ibus_valid/ibus_addr, ibus_rdata/ibus_ready       instruction bus
//   dbus_valid[N_DBUS], shared dbus_addr/wdata/wstrb, dbus_rdata/ready slices
//   bus_err/err_addr                                  sticky timeout report
// Optional feature: define BUS_TIMEOUT_EN to abandon accesses whose ready does
// not arrive within 2**TIMEOUT_W-1 issue cycles; otherwise ISSUE waits forever.
module iob_cpu_bus_split
  import iob_cpu_bus_split_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned N_DBUS    = 2,
  parameter int unsigned TIMEOUT_W = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     boot,
  input  logic                     cpu_valid,
  input  logic                     cpu_instr,
  input  logic [ADDR_W-1:0]        cpu_addr,
  input  logic [DATA_W-1:0]        cpu_wdata,
  input  logic [DATA_W/8-1:0]      cpu_wstrb,
  output logic [DATA_W-1:0]        cpu_rdata,
  output logic                     cpu_ready,
  output logic                     ibus_valid,
  output logic [ADDR_W-1:0]        ibus_addr,
  input  logic [DATA_W-1:0]        ibus_rdata,
  input  logic                     ibus_ready,
  output logic [N_DBUS-1:0]        dbus_valid,
  output logic [ADDR_W-1:0]        dbus_addr,
  output logic [DATA_W-1:0]        dbus_wdata,
  output logic [DATA_W/8-1:0]      dbus_wstrb,
  input  logic [N_DBUS*DATA_W-1:0] dbus_rdata,
  input  logic [N_DBUS-1:0]        dbus_ready,
  output logic                     bus_err,
  output logic [ADDR_W-1:0]        err_addr
);

  localparam int unsigned StrbW    = DATA_W / 8;
  localparam int unsigned SelW     = $clog2(N_DBUS);
  localparam int unsigned RemapBit = remap_bit(ADDR_W);

  bus_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [StrbW-1:0]  wstrb_q, wstrb_d;
  logic              instr_q, instr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [SelW-1:0]   port_sel;
  logic              issue;
  logic              sel_ready;
  logic [DATA_W-1:0] sel_rdata;
  logic              timeout;

  assign issue    = (state_q == StIssue);
  // Data port is chosen by the top address bits of the registered request.
  assign port_sel = addr_q[ADDR_W-1 -: SelW];

  // Only the selected bus can complete the access; all other readies are ignored.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    if (instr_q) begin
      sel_ready = ibus_ready;
      sel_rdata = ibus_rdata;
    end else begin
      sel_ready = dbus_ready[port_sel];
      for (int i = 0; i < int'(N_DBUS); i++) begin
        if (port_sel == SelW'(i)) sel_rdata = dbus_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Instruction address: remap bit is replaced by ~boot.
  always_comb begin
    ibus_addr           = addr_q;
    ibus_addr[RemapBit] = ~boot;
  end

  always_comb begin
    dbus_valid = '0;
    if (issue && !instr_q) dbus_valid[port_sel] = 1'b1;
  end

  assign ibus_valid = issue && instr_q;
  assign dbus_addr  = addr_q;
  assign dbus_wdata = wdata_q;
  assign dbus_wstrb = wstrb_q;
  assign cpu_ready  = (state_q == StResp);
  assign cpu_rdata  = rdata_q;

`ifdef BUS_TIMEOUT_EN
  logic [ADDR_W-1:0] bus_addr;
  assign bus_addr = instr_q ? ibus_addr : addr_q;

  iob_bus_timeout #(
    .TIMEOUT_W(TIMEOUT_W),
    .ADDR_W   (ADDR_W)
  ) u_bus_timeout (
    .clk_i     (clk),
    .rst_ni    (resetn),
    .issue_i   (issue),
    .ready_i   (sel_ready),
    .addr_i    (bus_addr),
    .timeout_o (timeout),
    .bus_err_o (bus_err),
    .err_addr_o(err_addr)
  );
`else
  logic [TIMEOUT_W-1:0] unused_timeout_w;
  assign unused_timeout_w = '0;
  assign timeout          = 1'b0;
  assign bus_err          = 1'b0;
  assign err_addr         = '0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    instr_d = instr_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (cpu_valid) begin
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          // Fetches are read-only: drop any strobes the CPU presented.
          wstrb_d = cpu_instr ? '0 : cpu_wstrb;
          instr_d = cpu_instr;
          state_d = StIssue;
        end
      end
      StIssue: begin
        // Ready has priority over a timeout in the same cycle.
        if (sel_ready) begin
          rdata_d = sel_rdata;
          state_d = StResp;
        end else if (timeout) begin
          rdata_d = '0;
          state_d = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      instr_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      instr_q <= instr_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_iob_cpu_bus_split.sv
// Self-checking bench for iob_cpu_bus_split (default N_DBUS=2, TIMEOUT_W=4).
// Timeout scenarios are compiled in when BUS_TIMEOUT_EN is defined.
module tb_iob_cpu_bus_split;

  localparam int unsigned AW         = 32;
  localparam int unsigned DW         = 32;
  localparam int unsigned SW         = DW / 8;
  localparam int unsigned ND         = 2;
  localparam int unsigned TW         = 4;
  localparam int unsigned SelW       = $clog2(ND);
  localparam int unsigned TmoCycles  = (1 << TW) - 1;
  localparam logic [AW-1:0] MsbMask  = {1'b1, {(AW-1){1'b0}}};

  logic              clk = 1'b0;
  logic              resetn;
  logic              boot;
  logic              cpu_valid, cpu_instr;
  logic [AW-1:0]     cpu_addr;
  logic [DW-1:0]     cpu_wdata;
  logic [SW-1:0]     cpu_wstrb;
  logic [DW-1:0]     cpu_rdata;
  logic              cpu_ready;
  logic              ibus_valid;
  logic [AW-1:0]     ibus_addr;
  logic [DW-1:0]     ibus_rdata;
  logic              ibus_ready;
  logic [ND-1:0]     dbus_valid;
  logic [AW-1:0]     dbus_addr;
  logic [DW-1:0]     dbus_wdata;
  logic [SW-1:0]     dbus_wstrb;
  logic [ND*DW-1:0]  dbus_rdata;
  logic [ND-1:0]     dbus_ready;
  logic              bus_err;
  logic [AW-1:0]     err_addr;

  always #5 clk = ~clk;

  iob_cpu_bus_split #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .N_DBUS   (ND),
    .TIMEOUT_W(TW)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .boot      (boot),
    .cpu_valid (cpu_valid),
    .cpu_instr (cpu_instr),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_wstrb (cpu_wstrb),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .ibus_valid(ibus_valid),
    .ibus_addr (ibus_addr),
    .ibus_rdata(ibus_rdata),
    .ibus_ready(ibus_ready),
    .dbus_valid(dbus_valid),
    .dbus_addr (dbus_addr),
    .dbus_wdata(dbus_wdata),
    .dbus_wstrb(dbus_wstrb),
    .dbus_rdata(dbus_rdata),
    .dbus_ready(dbus_ready),
    .bus_err   (bus_err),
    .err_addr  (err_addr)
  );

  typedef struct {
    bit          instr;
    bit          tmo;
    int          delay;
    int          port;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic [DW-1:0] rdata;
    logic [ND:0]   exp_valid;  // {ibus_valid, dbus_valid}
  } plan_t;

  typedef struct {
    logic [DW-1:0] rdata;
    bit            err;
    logic [AW-1:0] err_addr;
  } exp_t;

  plan_t plan_q[$];
  exp_t  exp_q[$];

  int            checks = 0;
  int            errors = 0;
  bit            rsp_en;
  bit            model_err;
  logic [AW-1:0] model_err_addr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit any_valid();
    return ibus_valid || (dbus_valid != '0);
  endfunction

  // Issue one CPU request, record its bus plan and expected response, then
  // wait (bounded) until the response has been consumed.
  task automatic issue_txn(input bit instr, input bit bt, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [SW-1:0] wstrb,
                           input int delay, input bit tmo, input logic [DW-1:0] rdata);
    plan_t p;
    exp_t  e;
    p.instr = instr;
    p.tmo   = tmo;
    p.delay = delay;
    p.wdata = wdata;
    p.wstrb = wstrb;
    p.rdata = rdata;
    if (instr) begin
      p.port      = 0;
      p.bus_addr  = (addr & ~MsbMask) | (bt ? '0 : MsbMask);
      p.exp_valid = (ND+1)'(1) << ND;
    end else begin
      p.port      = int'(addr >> (AW - SelW));
      p.bus_addr  = addr;
      p.exp_valid = (ND+1)'(1) << p.port;
    end
    e.rdata = tmo ? '0 : rdata;
    if (tmo && !model_err) begin
      model_err      = 1'b1;
      model_err_addr = p.bus_addr;
    end
    e.err      = model_err;
    e.err_addr = model_err_addr;
    plan_q.push_back(p);
    exp_q.push_back(e);

    @(negedge clk);
    boot      = bt;
    cpu_valid = 1'b1;
    cpu_instr = instr;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    cpu_wstrb = wstrb;
    @(negedge clk);
    cpu_valid = 1'b0;
    cpu_addr  = AW'($urandom);
    cpu_wdata = DW'($urandom);
    cpu_wstrb = SW'($urandom);
    chk("issue_latency", 64'(any_valid()), 64'(1));
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL txn_done: got %0d pending responses expected 0", exp_q.size());
      exp_q.delete();
      plan_q.delete();
    end
  endtask

  // Bus-side responder: checks what the DUT presents each issue cycle and
  // answers after the planned delay, with stray readies on other buses.
  initial begin : responder
    plan_t p;
    int    n_issue;
    bit    hit;
    ibus_ready = 1'b0;
    dbus_ready = '0;
    ibus_rdata = '0;
    dbus_rdata = '0;
    forever begin
      @(negedge clk);
      if (rsp_en && resetn && plan_q.size() != 0 && any_valid()) begin
        p       = plan_q.pop_front();
        n_issue = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
          chk("bus_valid", 64'({ibus_valid, dbus_valid}), 64'(p.exp_valid));
          if (p.instr) begin
            chk("ibus_addr", 64'(ibus_addr), 64'(p.bus_addr));
          end else begin
            chk("dbus_addr", 64'(dbus_addr), 64'(p.bus_addr));
            chk("dbus_wdata", 64'(dbus_wdata), 64'(p.wdata));
            chk("dbus_wstrb", 64'(dbus_wstrb), 64'(p.wstrb));
          end
          hit = !p.tmo && (cyc == p.delay);
          ibus_rdata = DW'($urandom);
          for (int i = 0; i < int'(ND); i++) dbus_rdata[i*DW +: DW] = DW'($urandom);
          dbus_ready = ND'($urandom);
          if (p.instr) begin
            ibus_ready = hit;
            if (hit) ibus_rdata = p.rdata;
          end else begin
            ibus_ready            = 1'($urandom);
            dbus_ready[p.port]    = hit;
            if (hit) dbus_rdata[p.port*DW +: DW] = p.rdata;
          end
          @(negedge clk);
          ibus_ready = 1'b0;
          dbus_ready = '0;
          n_issue    = cyc + 1;
          if (hit || !any_valid()) break;
        end
        chk("valid_drop", 64'(any_valid()), 64'(0));
        if (p.tmo) chk("timeout_cycles", 64'(n_issue), 64'(TmoCycles));
        else       chk("issue_cycles", 64'(n_issue), 64'(p.delay + 1));
      end
    end
  end

  // Response monitor: every cpu_ready must match the oldest expectation and
  // must directly follow a cycle in which a bus valid was up.
  initial begin : monitor
    exp_t e;
    bit   prev_valid;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (cpu_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_cpu_ready: got cpu_ready 1 expected 0 at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("cpu_rdata", 64'(cpu_rdata), 64'(e.rdata));
          chk("bus_err", 64'(bus_err), 64'(e.err));
          chk("err_addr", 64'(err_addr), 64'(e.err_addr));
          chk("resp_after_issue", 64'(prev_valid), 64'(1));
        end
      end
      prev_valid = any_valid();
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish expected finish within 50000 cycles");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    resetn         = 1'b0;
    boot           = 1'b0;
    cpu_valid      = 1'b0;
    cpu_instr      = 1'b0;
    cpu_addr       = '0;
    cpu_wdata      = '0;
    cpu_wstrb      = '0;
    rsp_en         = 1'b1;
    model_err      = 1'b0;
    model_err_addr = '0;
    repeat (3) @(negedge clk);
    chk("rst_cpu_ready", 64'(cpu_ready), 64'(0));
    chk("rst_cpu_rdata", 64'(cpu_rdata), 64'(0));
    chk("rst_ibus_valid", 64'(ibus_valid), 64'(0));
    chk("rst_dbus_valid", 64'(dbus_valid), 64'(0));
    chk("rst_bus_err", 64'(bus_err), 64'(0));
    chk("rst_err_addr", 64'(err_addr), 64'(0));
    resetn = 1'b1;

    // Fetch at 0x100: remap bit becomes ~boot.
    issue_txn(1'b1, 1'b0, 32'h0000_0100, '0, '0, 1, 1'b0, 32'h0000_0013);
    issue_txn(1'b1, 1'b1, 32'h0000_0100, '0, 4'hF, 1, 1'b0, 32'h0000_0013);
    // Write to port 1, stray readies on port 0 / ibus ignored.
    issue_txn(1'b0, 1'b0, 32'h8000_0010, 32'hCAFE_F00D, 4'hF, 4, 1'b0, 32'h1357_9BDF);
    // Long read on port 0, then minimum-latency read.
    issue_txn(1'b0, 1'b1, 32'h0000_0020, 32'h0, 4'h0, 10, 1'b0, 32'hA5A5_0001);
    issue_txn(1'b0, 1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0, 0, 1'b0, 32'hDEAD_BEEF);

`ifdef BUS_TIMEOUT_EN
    issue_txn(1'b0, 1'b0, 32'h8000_0044, 32'h1111_2222, 4'h3, 0, 1'b1, 32'h0);
    issue_txn(1'b1, 1'b0, 32'h0000_0088, 32'h0, 4'h0, 0, 1'b1, 32'h0);
    // Ready in the last allowed cycle beats the timeout.
    issue_txn(1'b0, 1'b0, 32'h0000_0030, 32'h0, 4'h0, TmoCycles - 1, 1'b0, 32'h0BAD_F00D);
`endif

    for (int n = 0; n < 200; n++) begin
      bit tmo;
      tmo = 1'b0;
`ifdef BUS_TIMEOUT_EN
      tmo = ($urandom_range(0, 7) == 0);
`endif
      issue_txn(1'($urandom), 1'($urandom), AW'($urandom), DW'($urandom), SW'($urandom),
                int'($urandom_range(0, 12)), tmo, DW'($urandom));
    end

    // Reset in the middle of an access; the access must never complete.
    rsp_en = 1'b0;
    @(negedge clk);
    boot      = 1'b0;
    cpu_valid = 1'b1;
    cpu_instr = 1'b0;
    cpu_addr  = 32'h8000_0040;
    @(negedge clk);
    cpu_valid = 1'b0;
    @(negedge clk);
    chk("abort_issue", 64'(dbus_valid), 64'(2'b10));
    resetn = 1'b0;
    @(negedge clk);
    chk("abort_cpu_ready", 64'(cpu_ready), 64'(0));
    chk("abort_cpu_rdata", 64'(cpu_rdata), 64'(0));
    chk("abort_ibus_valid", 64'(ibus_valid), 64'(0));
    chk("abort_dbus_valid", 64'(dbus_valid), 64'(0));
    chk("abort_bus_err", 64'(bus_err), 64'(0));
    chk("abort_err_addr", 64'(err_addr), 64'(0));
    model_err      = 1'b0;
    model_err_addr = '0;
    resetn     = 1'b1;
    ibus_ready = 1'b1;
    dbus_ready = '1;
    @(negedge clk);
    @(negedge clk);
    ibus_ready = 1'b0;
    dbus_ready = '0;
    for (int i = 0; i < 6; i++) begin
      chk("no_ready_after_reset", 64'(cpu_ready), 64'(0));
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
